flp_add_pipe: RTL and testbench

Pipelined, parametrised floating-point adder/subtractor for the VxEngine FP datapath. It accepts one operand pair per cycle and returns one packed result per cycle after a fixed 4-cycle latency. A per-operation add/sub select, a global pipeline enable for back-pressure and exception flags extend the combinational adder path into a streaming unit that vector lanes can instantiate directly.

---
 rtl/flp_add_pipe.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_flp_add_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flp_add_pipe.sv
// flp_add_pipe -- four-stage pipelined floating-point adder/subtractor.
//
// Accepts one operand pair per enabled cycle and returns the packed result
// four enabled edges later. Denormal inputs are flushed to zero. Rounding is
// to nearest with ties away from zero, using RSWIDTH guard bits; bits shifted
// out below the guard bits during alignment are truncated.
//
// Optional feature macro: FLP_ADD_PIPE_STICKY_EN
//   defined     : o_flags accumulates flags of every valid result, cleared by
//                 i_flags_clr (on any edge, regardless of i_en).
//   not defined : o_flags describes only the result currently on o_p and is
//                 zero while o_valid is low; i_flags_clr is ignored.
//
// Parameters:
//   EWIDTH   exponent width
//   SWIDTH   stored significand width (hidden bit excluded)
//   RSWIDTH  guard bits kept below the significand LSB
//   FWIDTH   packed width, 1+EWIDTH+SWIDTH (derived)
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   i_en         pipeline advance; 0 freezes every stage and output register
//   i_valid      operand pair present this cycle
//   i_op         0 = a+b, 1 = a-b
//   i_a, i_b     packed operands
//   i_flags_clr  clear sticky flags (sticky build only)
//   o_valid      o_p holds a result
//   o_p          packed result
//   o_flags      {nan, inf, ovf, unf}
//
// Flow control: there is no ready signal. A pair is taken whenever i_valid=1
// on an edge with i_en=1; the valid bit rides alongside the data through all
// four stages and every stage register (valid included) loads only on edges
// with i_en=1, so dropping i_en stalls the whole pipe and ignores inputs.
module flp_add_pipe #(
  parameter int EWIDTH  = 8,
  parameter int SWIDTH  = 23,
  parameter int RSWIDTH = 2,
  localparam int FWIDTH = 1 + EWIDTH + SWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_valid,
  input  logic              i_op,
  input  logic [FWIDTH-1:0] i_a,
  input  logic [FWIDTH-1:0] i_b,
  input  logic              i_flags_clr,
  output logic              o_valid,
  output logic [FWIDTH-1:0] o_p,
  output logic [3:0]        o_flags
);

  localparam int MW  = SWIDTH + RSWIDTH + 1;  // aligned significand width
  localparam int SW  = MW + 1;                // sum width incl. carry
  localparam int XW  = EWIDTH + 2;            // signed exponent arithmetic
  localparam int LZW = $clog2(SW + 1);

  typedef struct packed {
    logic nan;
    logic inf;
    logic inf_sign;
  } spec_t;

  // ---------------------------------------------------------------- stage 1
  logic              sign_a, sign_b;
  logic [EWIDTH-1:0] exp_a, exp_b;
  logic [SWIDTH-1:0] frac_a, frac_b;
  logic              zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [SWIDTH:0]   man_a, man_b;
  logic              swap;
  logic [EWIDTH-1:0] big_exp, small_exp, shift;
  logic [SWIDTH:0]   big_man, small_man;
  logic              big_sign, small_sign;
  logic [MW-1:0]     big_al, small_al;
  spec_t             in_spec;

  assign sign_a = i_a[FWIDTH-1];
  assign sign_b = i_b[FWIDTH-1] ^ i_op;  // effective sign of b
  assign exp_a  = i_a[FWIDTH-2 -: EWIDTH];
  assign exp_b  = i_b[FWIDTH-2 -: EWIDTH];
  assign frac_a = i_a[SWIDTH-1:0];
  assign frac_b = i_b[SWIDTH-1:0];

  assign zero_a = (exp_a == '0);
  assign zero_b = (exp_b == '0);
  assign inf_a  = (exp_a == '1) && (frac_a == '0);
  assign inf_b  = (exp_b == '1) && (frac_b == '0);
  assign nan_a  = (exp_a == '1) && (frac_a != '0);
  assign nan_b  = (exp_b == '1) && (frac_b != '0);

  // Zero exponent covers denormals too: the fraction is discarded.
  assign man_a = zero_a ? '0 : {1'b1, frac_a};
  assign man_b = zero_b ? '0 : {1'b1, frac_b};

  assign swap       = (exp_b > exp_a);
  assign big_exp    = swap ? exp_b  : exp_a;
  assign small_exp  = swap ? exp_a  : exp_b;
  assign big_man    = swap ? man_b  : man_a;
  assign small_man  = swap ? man_a  : man_b;
  assign big_sign   = swap ? sign_b : sign_a;
  assign small_sign = swap ? sign_a : sign_b;
  assign shift      = big_exp - small_exp;

  assign big_al   = {big_man, {RSWIDTH{1'b0}}};
  assign small_al = {small_man, {RSWIDTH{1'b0}}} >> shift;

  assign in_spec.nan      = nan_a | nan_b | (inf_a & inf_b & (sign_a ^ sign_b));
  assign in_spec.inf      = inf_a | inf_b;
  assign in_spec.inf_sign = inf_a ? sign_a : sign_b;

  logic              s1_valid;
  logic [EWIDTH-1:0] s1_exp;
  logic [MW-1:0]     s1_big, s1_small;
  logic              s1_sign_big, s1_sign_small, s1_both_zero;
  spec_t             s1_spec;

  // ---------------------------------------------------------------- stage 2
  logic [SW-1:0] add_sum;
  logic          add_sign, add_zero;

  always_comb begin
    add_sum  = '0;
    add_sign = s1_sign_big;
    if (s1_sign_big == s1_sign_small) begin
      add_sum = {1'b0, s1_big} + {1'b0, s1_small};
    end else if (s1_big >= s1_small) begin
      add_sum = {1'b0, s1_big - s1_small};
    end else begin
      add_sum  = {1'b0, s1_small - s1_big};
      add_sign = s1_sign_small;
    end
    add_zero = (add_sum == '0);
    // Two zero inputs keep -0 only if both are negative; any other exact
    // zero (a true cancellation) is +0.
    if (s1_both_zero) begin
      add_sign = s1_sign_big & s1_sign_small;
    end else if (add_zero) begin
      add_sign = 1'b0;
    end
  end

  logic              s2_valid;
  logic [EWIDTH-1:0] s2_exp;
  logic [SW-1:0]     s2_sum;
  logic              s2_sign, s2_zero;
  spec_t             s2_spec;

  // ---------------------------------------------------------------- stage 3
  logic [LZW-1:0] lz;
  logic [SW-1:0]  norm;
  logic [XW-1:0]  norm_exp;

  always_comb begin
    lz = '0;
    // Scan upward so the highest set bit wins.
    for (int i = 0; i < SW; i++) begin
      if (s2_sum[i]) lz = LZW'(SW - 1 - i);
    end
  end

  assign norm = s2_sum << lz;
  // The sum's top bit sits one position above the hidden bit, hence +1.
  assign norm_exp = {2'b00, s2_exp} + XW'(1) - {{(XW-LZW){1'b0}}, lz};

  // Below the rounding bit only truncated bits remain; they do not affect
  // round-half-away once the guard MSB is known.
  logic unused_norm;
  assign unused_norm = &{1'b0, norm[RSWIDTH-1:0]};

  logic              s3_valid;
  logic [SWIDTH:0]   s3_mant;
  logic              s3_rnd;
  logic [XW-1:0]     s3_exp;
  logic              s3_sign, s3_zero;
  spec_t             s3_spec;

  // ---------------------------------------------------------------- stage 4
  logic [SWIDTH+1:0] rnd_sum;
  logic              rnd_carry;
  logic [SWIDTH-1:0] fin_frac;
  logic [XW-1:0]     fin_exp;
  logic              res_unf, res_ovf;
  logic [FWIDTH-1:0] res_p;
  logic [3:0]        res_flags;

  assign rnd_sum   = {1'b0, s3_mant} + {{(SWIDTH+1){1'b0}}, s3_rnd};
  assign rnd_carry = rnd_sum[SWIDTH+1];
  assign fin_frac  = rnd_carry ? rnd_sum[SWIDTH:1] : rnd_sum[SWIDTH-1:0];
  assign fin_exp   = s3_exp + {{(XW-1){1'b0}}, rnd_carry};

  // Negative or zero biased exponent cannot be encoded (no denormals);
  // all-ones and above would collide with inf/NaN.
  assign res_unf = fin_exp[XW-1] || (fin_exp == '0);
  assign res_ovf = !fin_exp[XW-1] && (fin_exp[XW-2:0] >= {1'b0, {EWIDTH{1'b1}}});

  always_comb begin
    res_p     = {s3_sign, fin_exp[EWIDTH-1:0], fin_frac};
    res_flags = 4'b0000;
    if (s3_spec.nan) begin
      res_p     = {1'b0, {EWIDTH{1'b1}}, 1'b1, {(SWIDTH-1){1'b0}}};
      res_flags = 4'b1000;
    end else if (s3_spec.inf) begin
      res_p     = {s3_spec.inf_sign, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
      res_flags = 4'b0100;
    end else if (s3_zero) begin
      res_p = {s3_sign, {(FWIDTH-1){1'b0}}};
    end else if (res_unf) begin
      res_p     = {s3_sign, {(FWIDTH-1){1'b0}}};
      res_flags = 4'b0001;
    end else if (res_ovf) begin
      res_p     = {s3_sign, {EWIDTH{1'b1}}, {SWIDTH{1'b0}}};
      res_flags = 4'b0110;
    end
  end

  // --------------------------------------------------------- stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s1_exp        <= '0;
      s1_big        <= '0;
      s1_small      <= '0;
      s1_sign_big   <= 1'b0;
      s1_sign_small <= 1'b0;
      s1_both_zero  <= 1'b0;
      s1_spec       <= '0;
      s2_valid      <= 1'b0;
      s2_exp        <= '0;
      s2_sum        <= '0;
      s2_sign       <= 1'b0;
      s2_zero       <= 1'b0;
      s2_spec       <= '0;
      s3_valid      <= 1'b0;
      s3_mant       <= '0;
      s3_rnd        <= 1'b0;
      s3_exp        <= '0;
      s3_sign       <= 1'b0;
      s3_zero       <= 1'b0;
      s3_spec       <= '0;
      o_valid       <= 1'b0;
      o_p           <= '0;
    end else if (i_en) begin
      s1_valid      <= i_valid;
      s1_exp        <= big_exp;
      s1_big        <= big_al;
      s1_small      <= small_al;
      s1_sign_big   <= big_sign;
      s1_sign_small <= small_sign;
      s1_both_zero  <= zero_a & zero_b;
      s1_spec       <= in_spec;

      s2_valid      <= s1_valid;
      s2_exp        <= s1_exp;
      s2_sum        <= add_sum;
      s2_sign       <= add_sign;
      s2_zero       <= add_zero;
      s2_spec       <= s1_spec;

      s3_valid      <= s2_valid;
      s3_mant       <= norm[SW-1 -: SWIDTH+1];
      s3_rnd        <= norm[RSWIDTH];
      s3_exp        <= norm_exp;
      s3_sign       <= s2_sign;
      s3_zero       <= s2_zero;
      s3_spec       <= s2_spec;

      o_valid       <= s3_valid;
      o_p           <= res_p;
    end
  end

  // ------------------------------------------------------------------ flags
`ifdef FLP_ADD_PIPE_STICKY_EN
  // Clear works even while stalled; a flagged result leaving on the same
  // edge as a clear still sets its flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_flags <= 4'b0000;
    end else if (i_flags_clr) begin
      o_flags <= (i_en && s3_valid) ? res_flags : 4'b0000;
    end else if (i_en && s3_valid) begin
      o_flags <= o_flags | res_flags;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_flags <= 4'b0000;
    end else if (i_en) begin
      o_flags <= s3_valid ? res_flags : 4'b0000;
    end
  end

  logic unused_clr;
  assign unused_clr = &{1'b0, i_flags_clr};
`endif

endmodule

// File: tb/tb_flp_add_pipe.sv
// Bench for flp_add_pipe (single precision instance plus a half-precision
// instance). Expected results come from a real-valued-style integer model
// and a tagged expected queue counting enabled edges.
module tb_flp_add_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_en = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_op = 1'b0;
  logic [31:0] i_a = '0;
  logic [31:0] i_b = '0;
  logic        i_flags_clr = 1'b0;
  logic        o_valid;
  logic [31:0] o_p;
  logic [3:0]  o_flags;

  logic        h_en = 1'b1;
  logic        h_valid = 1'b0;
  logic        h_op = 1'b0;
  logic [15:0] h_a = '0;
  logic [15:0] h_b = '0;
  logic        h_o_valid;
  logic [15:0] h_o_p;
  logic [3:0]  h_o_flags;

  flp_add_pipe u_dut (
    .clk(clk), .rst(rst), .i_en(i_en), .i_valid(i_valid), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .i_flags_clr(i_flags_clr),
    .o_valid(o_valid), .o_p(o_p), .o_flags(o_flags)
  );

  flp_add_pipe #(.EWIDTH(5), .SWIDTH(10), .RSWIDTH(2)) u_half (
    .clk(clk), .rst(rst), .i_en(h_en), .i_valid(h_valid), .i_op(h_op),
    .i_a(h_a), .i_b(h_b), .i_flags_clr(1'b0),
    .o_valid(h_o_valid), .o_p(h_o_p), .o_flags(h_o_flags)
  );

  // ------------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  // ------------------------------------------------------------ scoreboard
  int          checks = 0;
  int          fails = 0;
  int          en_edges = 0;
  logic [35:0] exp_q[$];   // {flags, p}
  int          tag_q[$];   // enabled edge that accepted the pair
  logic        exp_valid = 1'b0;
  logic [31:0] exp_p = '0;
  logic [3:0]  exp_flags = '0;
  logic [3:0]  sticky = '0;

  // Reference: exact integer arithmetic in units of 2^-25 relative to the
  // larger exponent (two guard bits, anything finer truncated), then
  // round half away from zero.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
    int ea, eb, e;
    logic sa, sb, sgn, an, bn, ai, bi;
    longint ma, mb, ta, tb, s, mag, r;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = b[31] ^ op;
    an = (ea == 255) && (a[22:0] != 0);
    bn = (eb == 255) && (b[22:0] != 0);
    ai = (ea == 255) && (a[22:0] == 0);
    bi = (eb == 255) && (b[22:0] == 0);
    if (an || bn || (ai && bi && (sa != sb))) return {4'b1000, 32'h7FC00000};
    if (ai) return {4'b0100, sa, 8'hFF, 23'h0};
    if (bi) return {4'b0100, sb, 8'hFF, 23'h0};
    if (ea == 0 && eb == 0) return {4'b0000, sa & sb, 31'h0};
    ma = (ea == 0) ? 64'sd0 : (longint'(a[22:0]) + (64'sd1 <<< 23));
    mb = (eb == 0) ? 64'sd0 : (longint'(b[22:0]) + (64'sd1 <<< 23));
    if (ea >= eb) begin
      e = ea; ta = ma * 4; tb = (mb * 4) >> (ea - eb);
    end else begin
      e = eb; tb = mb * 4; ta = (ma * 4) >> (eb - ea);
    end
    s = (sa ? -ta : ta) + (sb ? -tb : tb);
    if (s == 0) return 36'h0;
    sgn = (s < 0);
    mag = sgn ? -s : s;
    if (mag >= (64'sd1 <<< 26)) begin mag = mag / 2; e++; end
    while (mag < (64'sd1 <<< 25)) begin mag = mag * 2; e--; end
    r = (mag / 4) + ((mag / 2) % 2);
    if (r >= (64'sd1 <<< 24)) begin r = r / 2; e++; end
    if (e >= 255) return {4'b0110, sgn, 8'hFF, 23'h0};
    if (e <= 0) return {4'b0001, sgn, 31'h0};
    return {4'b0000, sgn, 8'(e), 23'(r)};
  endfunction

  function automatic logic [31:0] rand_fp(input int near_e);
    int k, e;
    logic s;
    logic [22:0] f;
    k = int'($urandom_range(0, 19));
    s = 1'($urandom);
    f = 23'($urandom);
    e = int'($urandom_range(1, 254));
    case (k)
      0: begin e = 0; f = '0; end
      1: begin e = 255; f = '0; end
      2: begin e = 255; f = f | 23'h1; end
      3: e = 0;
      4: e = 254;
      5: e = 1;
      default: if (k < 14) begin
        e = near_e + int'($urandom_range(0, 4)) - 2;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
      end
    endcase
    return {s, 8'(e), f};
  endfunction

  // ------------------------------------------------------------- driver
  // Drives one cycle from a negedge, updates the model at the posedge and
  // returns at the following negedge where outputs are sampled.
  task automatic step(input logic en, input logic v, input logic op,
                      input logic [31:0] a, input logic [31:0] b, input logic clr);
    logic [35:0] r;
    logic        out_now;
    i_en = en; i_valid = v; i_op = op; i_a = a; i_b = b; i_flags_clr = clr;
    @(posedge clk);
    out_now = 1'b0;
    r = '0;
    if (en) begin
      en_edges++;
      if (v) begin
        exp_q.push_back(ref_add(a, b, op));
        tag_q.push_back(en_edges);
      end
      if (tag_q.size() > 0 && tag_q[0] + 3 == en_edges) begin
        r = exp_q.pop_front();
        void'(tag_q.pop_front());
        out_now = 1'b1;
        exp_p = r[31:0];
      end
      exp_valid = out_now;
    end
`ifdef FLP_ADD_PIPE_STICKY_EN
    if (clr) sticky = out_now ? r[35:32] : 4'b0000;
    else if (out_now) sticky = sticky | r[35:32];
    exp_flags = sticky;
`else
    if (en) exp_flags = out_now ? r[35:32] : 4'b0000;
`endif
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  // -------------------------------------------------------------- tests
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
    checks++; if (o_p !== 32'h0) begin fails++; $display("FAIL reset_p: got %h want 00000000", o_p); end
    checks++; if (o_flags !== 4'h0) begin fails++; $display("FAIL reset_flags: got %b want 0000", o_flags); end
    checks++; if (h_o_valid !== 1'b0) begin fails++; $display("FAIL reset_half_valid: got %b want 0", h_o_valid); end
    rst = 1'b0;
  endtask

  logic [31:0] dir_a  [9] = '{32'h3F800000, 32'h3FC00000, 32'h3FC00000, 32'h7F800000, 32'h7F7FFFFF,
                              32'h3F800000, 32'h80000000, 32'h00800001, 32'hFF800000};
  logic [31:0] dir_b  [9] = '{32'h3F800000, 32'h3F000000, 32'h3F000000, 32'hFF800000, 32'h7F7FFFFF,
                              32'h3F800000, 32'h80000000, 32'h00800000, 32'h3F800000};
  logic        dir_op [9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] dir_p  [9] = '{32'h40000000, 32'h3F800000, 32'h40000000, 32'h7FC00000, 32'h7F800000,
                              32'h00000000, 32'h80000000, 32'h00000000, 32'hFF800000};
  logic [3:0]  dir_f  [9] = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0110,
                              4'b0000, 4'b0000, 4'b0001, 4'b0100};

  task automatic test_directed();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, dir_op[i], dir_a[i], dir_b[i], 1'b1);
      idle();
      idle();
      checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL dir%0d_early: o_valid got %b want 0", i, o_valid); end
      idle();
      checks++; if (o_valid !== 1'b1) begin fails++; $display("FAIL dir%0d_valid: got %b want 1", i, o_valid); end
      checks++; if (o_p !== dir_p[i]) begin fails++; $display("FAIL dir%0d_p: got %h want %h", i, o_p, dir_p[i]); end
      checks++; if (o_flags !== dir_f[i]) begin fails++; $display("FAIL dir%0d_flags: got %b want %b", i, o_flags, dir_f[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int n = 0; n < 500; n++) begin
      a = rand_fp(int'($urandom_range(100, 154)));
      b = rand_fp(int'(a[30:23]));
      step(($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 75), 1'($urandom), a, b,
           ($urandom_range(0, 99) < 10));
      checks++; if (o_valid !== exp_valid) begin fails++; $display("FAIL rnd_valid n=%0d: got %b want %b", n, o_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (o_p !== exp_p) begin fails++; $display("FAIL rnd_p n=%0d: got %h want %h", n, o_p, exp_p); end
      end
      checks++; if (o_flags !== exp_flags) begin fails++; $display("FAIL rnd_flags n=%0d: got %b want %b", n, o_flags, exp_flags); end
    end
    repeat (5) idle();
  endtask

  task automatic test_back_to_back();
    int n_out, sent;
    logic en, v;
    logic [31:0] a, b;
    n_out = 0;
    sent = 0;
    for (int c = 0; c < 18; c++) begin
      en = !(c >= 4 && c < 7);           // three stalled cycles mid-stream
      v  = (sent < 8) || !en;            // stalled cycles still present junk
      a  = rand_fp(127);
      b  = rand_fp(int'(a[30:23]));
      step(en, v, 1'($urandom), a, b, 1'b0);
      if (en && v) sent++;
      if (en && o_valid) n_out++;
      checks++; if (o_valid !== exp_valid) begin fails++; $display("FAIL b2b_valid c=%0d: got %b want %b", c, o_valid, exp_valid); end
      if (exp_valid) begin
        checks++; if (o_p !== exp_p) begin fails++; $display("FAIL b2b_p c=%0d: got %h want %h", c, o_p, exp_p); end
      end
      checks++; if (o_flags !== exp_flags) begin fails++; $display("FAIL b2b_flags c=%0d: got %b want %b", c, o_flags, exp_flags); end
    end
    checks++; if (n_out !== 8) begin fails++; $display("FAIL b2b_count: got %0d want 8", n_out); end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h3F800000, 32'h40000000, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    tag_q.delete();
    exp_valid = 1'b0;
    exp_flags = 4'b0000;
    sticky = 4'b0000;
    #1;
    checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid_now: got %b want 0", o_valid); end
    checks++; if (o_flags !== 4'b0000) begin fails++; $display("FAIL rstmid_flags: got %b want 0000", o_flags); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      idle();
      checks++; if (o_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid%0d: got %b want 0", i, o_valid); end
    end
  endtask

  task automatic test_half_precision();
    logic [15:0] ha [2] = '{16'h3C00, 16'h3E00};
    logic [15:0] hb [2] = '{16'h3C00, 16'h3800};
    logic        hop[2] = '{1'b0, 1'b1};
    logic [15:0] hp [2] = '{16'h4000, 16'h3C00};
    for (int i = 0; i < 2; i++) begin
      h_valid = 1'b1; h_a = ha[i]; h_b = hb[i]; h_op = hop[i];
      idle();
      h_valid = 1'b0;
      idle();
      idle();
      idle();
      checks++; if (h_o_valid !== 1'b1) begin fails++; $display("FAIL half%0d_valid: got %b want 1", i, h_o_valid); end
      checks++; if (h_o_p !== hp[i]) begin fails++; $display("FAIL half%0d_p: got %h want %h", i, h_o_p, hp[i]); end
      checks++; if (h_o_flags !== 4'b0000) begin fails++; $display("FAIL half%0d_flags: got %b want 0000", i, h_o_flags); end
    end
  endtask

`ifdef FLP_ADD_PIPE_STICKY_EN
  task automatic test_sticky();
    step(1'b1, 1'b1, 1'b0, 32'h7F800001, 32'h3F800000, 1'b1);
    repeat (3) idle();
    checks++; if (o_flags !== 4'b1000) begin fails++; $display("FAIL sticky_nan: got %b want 1000", o_flags); end
    repeat (2) idle();
    checks++; if (o_flags !== 4'b1000) begin fails++; $display("FAIL sticky_hold: got %b want 1000", o_flags); end
    step(1'b1, 1'b1, 1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0);
    repeat (3) idle();
    checks++; if (o_flags !== 4'b1110) begin fails++; $display("FAIL sticky_accum: got %b want 1110", o_flags); end
    step(1'b1, 1'b1, 1'b1, 32'hFF800000, 32'h3F800000, 1'b0);
    repeat (2) idle();
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (o_flags !== 4'b0100) begin fails++; $display("FAIL sticky_clr_vs_set: got %b want 0100", o_flags); end
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    checks++; if (o_flags !== 4'b0000) begin fails++; $display("FAIL sticky_clr_stalled: got %b want 0000", o_flags); end
    checks++; if (o_flags !== exp_flags) begin fails++; $display("FAIL sticky_model: got %b want %b", o_flags, exp_flags); end
  endtask
`endif

  // --------------------------------------------------------------- main
  initial begin
    test_reset();
    test_directed();
    test_half_precision();
    test_random();
    test_back_to_back();
`ifdef FLP_ADD_PIPE_STICKY_EN
    test_sticky();
`endif
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
